// File: rtl/int_ctrl.sv
// Interrupt controller: NUM_SRC synchronised level/edge sources, masking, fixed
// priority, optional nesting and an ack/EOI handshake toward a single-IRQ CPU.
module int_ctrl #(
  parameter int unsigned NUM_SRC    = 8,
  parameter logic [31:0] EDGE_MASK  = 32'h0,
  parameter int unsigned CAUSE_BASE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  output logic               int_req,
  output logic [31:0]        int_num,
  input  logic               int_ack,
  input  logic               eoi,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [NUM_SRC-1:0] EDGE_BITS = EDGE_MASK[NUM_SRC-1:0];

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync1_d;
  logic [NUM_SRC-1:0] sync2_q, sync2_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] isr_q, isr_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               int_req_q, int_req_d;
  logic [31:0]        int_num_q, int_num_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [NUM_SRC-1:0] edge_set, level_set, ack_clr, w1c_clr, clr_all;
  logic [NUM_SRC-1:0] isr_low, allowed, cand_vec;
  logic               cand_valid, ack_fire;
  logic [IDX_W-1:0]   cand_idx;
  logic               cfg_wdata_unused;

  // Upper write-data bits beyond NUM_SRC have no storage behind them.
  assign cfg_wdata_unused = ^cfg_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      isr_q     <= '0;
      ctrl_q    <= '0;
      int_req_q <= 1'b0;
      int_num_q <= '0;
      idx_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      isr_q     <= isr_d;
      ctrl_q    <= ctrl_d;
      int_req_q <= int_req_d;
      int_num_q <= int_num_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sync1_d   = irq;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    mask_d    = mask_q;
    ctrl_d    = ctrl_q;
    int_req_d = int_req_q;
    int_num_d = int_num_q;
    idx_d     = idx_q;
    cand_idx  = '0;

    ack_fire  = int_ack && (state_q == S_REQ);
    ack_clr   = ack_fire ? (NUM_SRC'(1) << idx_q) : '0;
    w1c_clr   = (cfg_we && (cfg_addr == 2'd1)) ? cfg_wdata[NUM_SRC-1:0] : '0;
    clr_all   = ack_clr | w1c_clr;
    edge_set  = sync2_q & ~prev_q & EDGE_BITS;
    level_set = sync2_q & ~EDGE_BITS;

    // An edge is never lost to a same-cycle clear; a still-high level re-pends next cycle.
    pending_d = (pending_q & ~clr_all) | edge_set | (level_set & ~clr_all);

    // EOI retires the highest-priority in-service source before a same-cycle ack lands.
    isr_low = isr_q & (~isr_q + NUM_SRC'(1));
    isr_d   = (eoi ? (isr_q & ~isr_low) : isr_q) | ack_clr;

    if (cfg_we && (cfg_addr == 2'd0)) mask_d = cfg_wdata[NUM_SRC-1:0];
    if (cfg_we && (cfg_addr == 2'd3)) ctrl_d = cfg_wdata[1:0];

    if (isr_q == '0) allowed = '1;
    else if (ctrl_q[1]) allowed = isr_low - NUM_SRC'(1);
    else allowed = '0;

    cand_vec   = pending_q & mask_q & allowed & {NUM_SRC{ctrl_q[0]}};
    cand_valid = |cand_vec;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand_vec[i]) cand_idx = IDX_W'(i);
    end

    case (state_q)
      S_IDLE: begin
        if (cand_valid) begin
          state_d   = S_REQ;
          int_req_d = 1'b1;
          int_num_d = 32'(CAUSE_BASE) + 32'(cand_idx);
          idx_d     = cand_idx;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          state_d   = S_IDLE;
          int_req_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (cfg_addr)
      2'd0:    cfg_rdata = 32'(mask_q);
      2'd1:    cfg_rdata = 32'(pending_q);
      2'd2:    cfg_rdata = 32'(isr_q);
      default: cfg_rdata = 32'(ctrl_q);
    endcase
  end

  assign int_req = int_req_q;
  assign int_num = int_num_q;

endmodule
